// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencer: PC, instr_mem address, one-entry decode stage
// Handles go/start, decode backpressure, execute redirects and HALT draining.
module fetch_ctrl #(
    parameter int               WIDTH    = 32,
    parameter int               PC_W     = 32,
    parameter logic [PC_W-1:0]  RESET_PC = '0,
    parameter logic [4:0]       HALT_OP  = 5'h1F
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    output logic [PC_W-1:0]  imem_pc,
    input  logic [WIDTH-1:0] imem_inst,
    output logic             f_valid,
    input  logic             f_ready,
    output logic [WIDTH-1:0] f_inst,
    output logic [PC_W-1:0]  f_pc,
    input  logic             redirect_valid,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic             halted
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              f_valid_q, f_valid_d;
    logic [WIDTH-1:0]  f_inst_q, f_inst_d;
    logic [PC_W-1:0]   f_pc_q, f_pc_d;
    logic              fe;
    logic              xfer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            f_valid_q <= 1'b0;
            f_inst_q  <= '0;
            f_pc_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            f_valid_q <= f_valid_d;
            f_inst_q  <= f_inst_d;
            f_pc_q    <= f_pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        f_valid_d = f_valid_q;
        f_inst_d  = f_inst_q;
        f_pc_d    = f_pc_q;
        xfer      = f_valid_q & f_ready;
        fe        = (state_q == ST_RUN) & ~redirect_valid & (~f_valid_q | f_ready);

        case (state_q)
            ST_IDLE: begin
                // A redirect while idle just sets the boot address.
                if (redirect_valid) pc_d = redirect_pc;
                if (go) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    f_valid_d = 1'b0;
                    pc_d      = redirect_pc;
                end else if (fe) begin
                    f_inst_d  = imem_inst;
                    f_pc_d    = pc_q;
                    f_valid_d = 1'b1;
                    pc_d      = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
                    if (imem_inst[WIDTH-1:WIDTH-5] == HALT_OP) state_d = ST_DRAIN;
                end else if (xfer) begin
                    f_valid_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                // Held HALT may be on a mispredicted path; a redirect cancels it.
                if (redirect_valid) begin
                    f_valid_d = 1'b0;
                    pc_d      = redirect_pc;
                    state_d   = ST_RUN;
                end else if (xfer) begin
                    f_valid_d = 1'b0;
                    state_d   = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (go) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign imem_pc = pc_q;
    assign f_valid = f_valid_q;
    assign f_inst  = f_inst_q;
    assign f_pc    = f_pc_q;
    assign halted  = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed vector table plus randomized run against a queue-based fetch model
module tb_fetch_ctrl;

    localparam int         WIDTH = 32;
    localparam int         PC_W  = 32;
    localparam logic [4:0] OP_HALT = 5'h1F;
    localparam logic [4:0] OP_MOV  = 5'h01;
    localparam logic [4:0] OP_ADD  = 5'h02;
    localparam logic [4:0] OP_CMP  = 5'h03;
    localparam logic [4:0] OP_BR   = 5'h04;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             go = 1'b0;
    logic [PC_W-1:0]  imem_pc;
    logic [WIDTH-1:0] imem_inst;
    logic             f_valid;
    logic             f_ready = 1'b0;
    logic [WIDTH-1:0] f_inst;
    logic [PC_W-1:0]  f_pc;
    logic             redirect_valid = 1'b0;
    logic [PC_W-1:0]  redirect_pc = '0;
    logic             halted;

    logic [WIDTH-1:0] mem [64];
    assign imem_inst = mem[imem_pc[5:0]];

    fetch_ctrl #(.WIDTH(WIDTH), .PC_W(PC_W), .RESET_PC('0), .HALT_OP(OP_HALT)) dut (
        .clk(clk), .rst(rst), .go(go), .imem_pc(imem_pc), .imem_inst(imem_inst),
        .f_valid(f_valid), .f_ready(f_ready), .f_inst(f_inst), .f_pc(f_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [127:0] pack(input logic v, input logic [PC_W-1:0] p,
                                          input logic [WIDTH-1:0] i, input logic [PC_W-1:0] ip,
                                          input logic h);
        return {30'd0, v, v ? p : '0, v ? i : '0, ip, h};
    endfunction

    function automatic logic [127:0] observed();
        return pack(f_valid, f_pc, f_inst, imem_pc, halted);
    endfunction

    // Reference model: the decode stage is a queue holding at most one word.
    typedef struct { logic [WIDTH-1:0] inst; logic [PC_W-1:0] pc; } word_t;
    typedef enum { M_IDLE, M_RUN, M_DRAIN, M_HALTED } mode_t;
    mode_t            m_mode;
    logic [PC_W-1:0]  m_pc;
    word_t            m_q[$];

    task automatic model_step(input logic g, input logic rdy, input logic rv, input logic [PC_W-1:0] rpc);
        word_t w;
        bit    taken;
        w.inst = mem[m_pc[5:0]];
        w.pc   = m_pc;
        taken  = (m_q.size() > 0) && rdy;
        case (m_mode)
            M_IDLE: begin
                if (rv) m_pc = rpc;
                if (g) m_mode = M_RUN;
            end
            M_RUN: begin
                if (rv) begin
                    m_q.delete();
                    m_pc = rpc;
                end else begin
                    if (taken) void'(m_q.pop_front());
                    if (m_q.size() == 0) begin
                        m_q.push_back(w);
                        m_pc = m_pc + 1;
                        if (w.inst[WIDTH-1 -: 5] == OP_HALT) m_mode = M_DRAIN;
                    end
                end
            end
            M_DRAIN: begin
                if (rv) begin
                    m_q.delete();
                    m_pc   = rpc;
                    m_mode = M_RUN;
                end else if (taken) begin
                    void'(m_q.pop_front());
                    m_mode = M_HALTED;
                end
            end
            M_HALTED: if (g) m_mode = M_RUN;
        endcase
    endtask

    function automatic logic [127:0] model_expect();
        if (m_q.size() > 0)
            return pack(1'b1, m_q[0].pc, m_q[0].inst, m_pc, m_mode == M_HALTED);
        return pack(1'b0, '0, '0, m_pc, m_mode == M_HALTED);
    endfunction

    typedef struct {
        logic go; logic rdy; logic rv; int rpc;
        logic ev; int efpc; int eimem; logic eh;
    } vec_t;
    vec_t vecs[25];

    initial begin
        logic [WIDTH-1:0] e_inst;
        for (int i = 0; i < 64; i++) mem[i] = {OP_MOV, 27'(i)};
        mem[0] = {OP_MOV, 27'd0};  mem[1] = {OP_MOV, 27'd1};  mem[2] = {OP_MOV, 27'd2};
        mem[3] = {OP_ADD, 27'd3};  mem[4] = {OP_CMP, 27'd4};  mem[5] = {OP_BR,  27'd5};
        mem[6] = {OP_HALT, 27'd6}; mem[7] = {OP_MOV, 27'd7};

        //          go rdy rv rpc  ev fpc imem h
        vecs[0]  = '{1, 1, 0, 0,   0, 0, 0, 0};
        vecs[1]  = '{0, 1, 0, 0,   1, 0, 1, 0};
        vecs[2]  = '{0, 1, 0, 0,   1, 1, 2, 0};
        vecs[3]  = '{0, 1, 0, 0,   1, 2, 3, 0};
        vecs[4]  = '{0, 0, 0, 0,   1, 2, 3, 0};
        vecs[5]  = '{0, 0, 0, 0,   1, 2, 3, 0};
        vecs[6]  = '{0, 0, 0, 0,   1, 2, 3, 0};
        vecs[7]  = '{0, 1, 0, 0,   1, 3, 4, 0};
        vecs[8]  = '{0, 1, 0, 0,   1, 4, 5, 0};
        vecs[9]  = '{0, 1, 0, 0,   1, 5, 6, 0};
        vecs[10] = '{0, 1, 1, 3,   0, 0, 3, 0};
        vecs[11] = '{0, 1, 0, 0,   1, 3, 4, 0};
        vecs[12] = '{0, 1, 0, 0,   1, 4, 5, 0};
        vecs[13] = '{0, 1, 0, 0,   1, 5, 6, 0};
        vecs[14] = '{0, 1, 0, 0,   1, 6, 7, 0};
        vecs[15] = '{0, 0, 0, 0,   1, 6, 7, 0};
        vecs[16] = '{0, 1, 0, 0,   0, 0, 7, 1};
        vecs[17] = '{0, 1, 1, 0,   0, 0, 7, 1};
        vecs[18] = '{1, 1, 0, 0,   0, 0, 7, 0};
        vecs[19] = '{0, 1, 0, 0,   1, 7, 8, 0};
        vecs[20] = '{0, 1, 1, 5,   0, 0, 5, 0};
        vecs[21] = '{0, 1, 0, 0,   1, 5, 6, 0};
        vecs[22] = '{0, 1, 0, 0,   1, 6, 7, 0};
        vecs[23] = '{0, 0, 1, 3,   0, 0, 3, 0};
        vecs[24] = '{0, 1, 0, 0,   1, 3, 4, 0};

        #2 rst = 1'b0;
        #1;
        check("reset_state", {observed(), f_inst}, {pack(1'b0, '0, '0, '0, 1'b0), 32'd0});

        for (int i = 0; i < 25; i++) begin
            go             = vecs[i].go;
            f_ready        = vecs[i].rdy;
            redirect_valid = vecs[i].rv;
            redirect_pc    = PC_W'(vecs[i].rpc);
            @(posedge clk); #1;
            e_inst = mem[vecs[i].efpc];
            check($sformatf("vec%0d", i), observed(),
                  pack(vecs[i].ev, PC_W'(vecs[i].efpc), e_inst, PC_W'(vecs[i].eimem), vecs[i].eh));
        end
        go = 1'b0; redirect_valid = 1'b0;

        // Async reset mid-cycle with an instruction held.
        f_ready = 1'b1;
        @(posedge clk); #1;
        check("pre_reset_valid", observed(), pack(1'b1, 32'd4, mem[4], 32'd5, 1'b0));
        #2 rst = 1'b1;
        #1 check("async_reset", {observed(), f_inst}, {pack(1'b0, '0, '0, '0, 1'b0), 32'd0});
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("idle_after_reset%0d", i), observed(), pack(1'b0, '0, '0, '0, 1'b0));
        end

        // Randomized run; DUT is idle at pc 0, model starts the same way.
        for (int i = 0; i < 64; i++)
            mem[i] = {($urandom_range(0, 7) == 0) ? OP_HALT : 5'($urandom_range(0, 30)), 27'($urandom)};
        m_mode = M_IDLE;
        m_pc   = '0;
        m_q.delete();
        for (int c = 0; c < 2000; c++) begin
            go             = ($urandom_range(0, 7) == 0);
            f_ready        = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = PC_W'($urandom_range(0, 63));
            model_step(go, f_ready, redirect_valid, redirect_pc);
            @(posedge clk); #1;
            check($sformatf("rand%0d", c), observed(), model_expect());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
